// File: rtl/sp_ram_arb2.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a one-cycle read latency.
// Each granted access returns exactly one rvalid pulse, to its owner, in the following cycle.
module sp_ram_arb2 #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    logic                  last_q;
    logic                  rsp_valid_q;
    logic                  rsp_owner_q;
    logic                  rsp_we_q;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  grant_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;

    // Round-robin arbitration; grants are held low while reset is asserted.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0_req_i && m1_req_i) begin
            gnt0_s = last_q;
            gnt1_s = ~last_q;
        end else if (m0_req_i) begin
            gnt0_s = 1'b1;
        end else if (m1_req_i) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign grant_s  = gnt0_s | gnt1_s;
    assign m0_gnt_o = gnt0_s;
    assign m1_gnt_o = gnt1_s;

    // RAM pin mux from the granted requester; all zero when idle.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        if (gnt1_s) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_we_o    = m1_we_i;
            mem_be_o    = m1_be_i;
        end else if (gnt0_s) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_we_o    = m0_we_i;
            mem_be_o    = m0_be_i;
        end else begin
            mem_en_o    = 1'b0;
        end
    end

    // Arbitration history and the pending-response tag for the access granted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= grant_s;
            if (grant_s) begin
                last_q      <= gnt1_s;
                rsp_owner_q <= gnt1_s;
                rsp_we_q    <= mem_we_o;
            end else begin
                last_q      <= last_q;
                rsp_owner_q <= rsp_owner_q;
                rsp_we_q    <= rsp_we_q;
            end
        end
    end

    // Write responses carry zero data; read responses carry the RAM output.
    always_comb begin
        rsp_data_s = '0;
        if (rsp_we_q) begin
            rsp_data_s = '0;
        end else begin
            rsp_data_s = mem_rdata_i;
        end
    end

    // Steer the response to its owner; idle ports see zero data.
    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        if (rsp_valid_q) begin
            if (rsp_owner_q) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = rsp_data_s;
            end else begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = rsp_data_s;
            end
        end else begin
            m0_rvalid_o = 1'b0;
            m1_rvalid_o = 1'b0;
        end
    end

endmodule

// File: doc/sp_ram_arb2.md
# sp_ram_arb2

Two-requester round-robin arbiter in front of the single-port `sp_ram` macro. It lets two bus masters share one RAM instance, for example the core data port and the AES DMA engine. It accepts req/gnt/rvalid handshakes on each requester port, grants at most one access per cycle, and drives the RAM's `en/addr/wdata/we/be` pins. It also tracks the one-cycle RAM read latency and routes read data back to the requester that issued the access.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte address width, passed through unchanged to the RAM.
- `DATA_WIDTH`, default 32: data width; must be a multiple of 8.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `m0_req_i`  in  1  requester 0 access request.
- `m0_gnt_o`  out  1  requester 0 request accepted this cycle.
- `m0_addr_i`  in  ADDR_WIDTH  requester 0 byte address.
- `m0_we_i`  in  1  requester 0 write enable (1 = write).
- `m0_be_i`  in  DATA_WIDTH/8  requester 0 byte enables.
- `m0_wdata_i`  in  DATA_WIDTH  requester 0 write data.
- `m0_rvalid_o`  out  1  response for requester 0's granted access.
- `m0_rdata_o`  out  DATA_WIDTH  requester 0 read data, valid with `m0_rvalid_o`.
- `m1_*`: same eight signals, same widths and meanings, for requester 1.
- `mem_en_o`  out  1  RAM enable.
- `mem_addr_o`  out  ADDR_WIDTH  RAM address.
- `mem_wdata_o`  out  DATA_WIDTH  RAM write data.
- `mem_we_o`  out  1  RAM write enable.
- `mem_be_o`  out  DATA_WIDTH/8  RAM byte enables.
- `mem_rdata_i`  in  DATA_WIDTH  RAM read data, registered inside the RAM, one cycle after enable.

## Operation
- State registers:
  - `last_q`: index of the last granted requester. Reset value 1, so requester 0 wins the first contention.
  - `rsp_valid_q`: a response is due this cycle.
  - `rsp_owner_q`: which requester the pending response belongs to.
- Arbitration is combinational and decided within the cycle:
  - Only `mN_req_i` high: grant N.
  - Both high: grant the requester not equal to `last_q`.
  - Neither high: no grant.
- Exactly zero or one `mN_gnt_o` is high in any cycle. `last_q` updates to the granted index only on a granted cycle; idle cycles do not change it.
- On a grant:
  - `mem_en_o` = 1.
  - `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are muxed from the granted requester.
- With no grant, `mem_en_o` = 0 and all other `mem_*` outputs are 0.
- Response: every granted access, read or write, produces exactly one `mN_rvalid_o` pulse to its owner in the following cycle.
  - Write responses carry `mN_rdata_o` = 0.
  - Read responses carry `mem_rdata_i`.
  - `mN_rdata_o` = 0 whenever `mN_rvalid_o` = 0.
- Requester rules:
  - The requester holds `req`, `addr`, `we`, `be` and `wdata` stable until it sees `gnt`.
  - A requester may drop `req` before `gnt`; that abandons the request, with no side effects.
  - The arbiter never back-pressures responses; requesters always accept `rvalid`.
- Fairness: a requester holding `req` high is granted within 2 cycles, i.e. it is denied at most one consecutive cycle.
- Byte enables pass through unchanged. A write with `be` = 0 is still granted, still enables the RAM, and still returns a response.

## Timing
- `gnt` is a zero-cycle combinational function of the `req` inputs and `last_q`. The RAM is enabled in the same cycle as the grant.
- `rvalid` is high exactly 1 cycle after the grant. Throughput is 1 access per cycle, including back-to-back accesses from alternating requesters.
- Grant and response overlap: a grant in cycle t+1 and the response for the grant in cycle t occur in the same cycle without conflict.
- Reset values, and values while `rst_n` = 0:
  - `m0_gnt_o` = `m1_gnt_o` = 0 (forced low while in reset).
  - `mem_en_o` = 0 and all `mem_*` outputs = 0.
  - `m0_rvalid_o` = `m1_rvalid_o` = 0 and both `rdata` outputs = 0.
- Reset asserted mid-operation:
  - Any pending response is dropped; `rsp_valid_q` clears asynchronously.
  - No `rvalid` appears after reset is released.
- Reset deassertion: the first rising edge after `rst_n` rises may grant.

## Test plan
- **Single read.** Preload word address 0x10 with 0xDEADBEEF. Assert `m0_req_i` with `addr` = 0x10 and `we` = 0.
  - Required: `m0_gnt_o` high in the same cycle with `mem_en_o` = 1 and `mem_addr_o` = 0x10.
  - Next cycle: `m0_rvalid_o` = 1 and `m0_rdata_o` = 0xDEADBEEF.
  - `m1_rvalid_o` stays 0 throughout.
- **Contention after reset.** Both requesters request continuously for 6 cycles.
  - Required grant sequence: m0, m1, m0, m1, m0, m1.
  - Each `rvalid` lands on the matching owner one cycle after its grant.
- **Byte-enable write then read.**
  - m1 writes 0xAABBCCDD to address 0x04 with `be` = 0xF, then writes 0x11223344 with `be` = 0x5.
  - m1 then reads address 0x04. Required read data: 0xAA22CC44.
  - Each write returns `rvalid` with `rdata` = 0.
- **Abandon.** m0 and m1 request in the same cycle; m1 loses and drops `req` in the next cycle.
  - Required: no m1 grant and no m1 `rvalid`.
  - `last_q` remains 0 across the following idle cycles.
- **Reset mid-response.** Grant a read from m0, then pulse `rst_n` low between the grant edge and the response edge.
  - Required: `m0_rvalid_o` never goes high.
  - All outputs are 0 while in reset.
  - The first contention after reset is granted to m0.
